// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter (with alu_share_pkg)
// Purpose  : Round-robin share of one single-cycle ALU between two cores,
//            with a one-entry writeback buffer per core.
// Revision : 1.0 - initial release
// ============================================================================

package alu_share_pkg;
   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2,
      ALU_XOR = 2'd3
   } alu_op_t;

   typedef struct packed {
      logic [31:0] in1;
      logic [31:0] in2;
      alu_op_t     op;
   } alu_inputs_t;
endpackage

module alu_share_arbiter
   import alu_share_pkg::*;
#(
   parameter int NUM_CORES   = 2,
   parameter int ID_W        = 3,
   parameter int XLEN        = 32,
   parameter int STALL_CNT_W = 16
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic        [NUM_CORES-1:0]             req_valid,
   input  logic        [NUM_CORES-1:0][ID_W-1:0]   req_id,
   input  alu_inputs_t [NUM_CORES-1:0]             req_inputs,
   output logic        [NUM_CORES-1:0]             req_grant,
   output logic                                    alu_possible_issue,
   output logic        [ID_W-1:0]                  alu_id,
   output alu_inputs_t                             alu_inputs,
   input  logic                                    alu_ready,
   input  logic                                    alu_done,
   input  logic        [ID_W-1:0]                  alu_wb_id,
   input  logic        [XLEN-1:0]                  alu_wb_rd,
   output logic        [NUM_CORES-1:0]             wb_valid,
   output logic        [NUM_CORES-1:0][ID_W-1:0]   wb_id,
   output logic        [NUM_CORES-1:0][XLEN-1:0]   wb_rd,
   input  logic        [NUM_CORES-1:0]             wb_ack,
   output logic        [NUM_CORES-1:0][STALL_CNT_W-1:0] stall_cnt
);

   logic                                  r_last_grant;
   logic                                  r_owner;
   logic                                  r_granted;
   logic [NUM_CORES-1:0]                  r_wb_valid;
   logic [NUM_CORES-1:0][ID_W-1:0]        r_wb_id;
   logic [NUM_CORES-1:0][XLEN-1:0]        r_wb_rd;
   logic [NUM_CORES-1:0][STALL_CNT_W-1:0] r_stall_cnt;

   logic [NUM_CORES-1:0]                  w_eligible;
   logic [NUM_CORES-1:0]                  w_grant;
   logic                                  w_sel;

   // A full buffer only blocks issue if it is not being drained this cycle.
   always_comb begin
      w_eligible = req_valid & {NUM_CORES{alu_ready}} & (~r_wb_valid | wb_ack);
      w_grant    = '0;
      w_sel      = 1'b0;
      if (rst) begin
         case (w_eligible)
            2'b01: begin w_grant = 2'b01; w_sel = 1'b0; end
            2'b10: begin w_grant = 2'b10; w_sel = 1'b1; end
            2'b11: begin
               w_sel   = ~r_last_grant;
               w_grant = r_last_grant ? 2'b01 : 2'b10;
            end
            default: begin w_grant = '0; w_sel = 1'b0; end
         endcase
      end
   end

   assign req_grant          = w_grant;
   assign alu_possible_issue = |w_grant;
   assign alu_id             = req_id[w_sel];
   assign alu_inputs         = req_inputs[w_sel];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last_grant <= 1'b1;
         r_owner      <= 1'b0;
         r_granted    <= 1'b0;
         r_wb_valid   <= '0;
         r_wb_id      <= '0;
         r_wb_rd      <= '0;
         r_stall_cnt  <= '0;
      end else begin
         r_granted <= |w_grant;
         if (|w_grant) begin
            r_last_grant <= w_sel;
            r_owner      <= w_sel;
         end
         for (int c = 0; c < NUM_CORES; c++) begin
            // A same-cycle capture wins over the ack of the older result.
            if (alu_done && w_grant[c]) begin
               r_wb_valid[c] <= 1'b1;
               r_wb_id[c]    <= alu_wb_id;
               r_wb_rd[c]    <= alu_wb_rd;
            end else if (wb_ack[c]) begin
               r_wb_valid[c] <= 1'b0;
            end
            if (req_valid[c] && !w_grant[c] && (r_stall_cnt[c] != '1)) begin
               r_stall_cnt[c] <= r_stall_cnt[c] + STALL_CNT_W'(1);
            end
         end
      end
   end

   assign wb_valid  = r_wb_valid;
   assign wb_id     = r_wb_id;
   assign wb_rd     = r_wb_rd;
   assign stall_cnt = r_stall_cnt;

   a_done_same_cycle : assert property (@(posedge clk) disable iff (!rst)
      alu_done == alu_possible_issue);
   a_wb_id_match : assert property (@(posedge clk) disable iff (!rst)
      alu_done |-> (alu_wb_id == alu_id));
   a_owner_captured : assert property (@(posedge clk) disable iff (!rst)
      r_granted |-> r_wb_valid[r_owner]);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Scoreboard bench for alu_share_arbiter with a stand-in ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
   import alu_share_pkg::*;

   localparam int SW = 4;
   localparam logic [SW-1:0] SMAX = '1;

   logic                        clk = 1'b0;
   logic                        rst = 1'b0;
   logic        [1:0]           req_valid;
   logic        [1:0][2:0]      req_id;
   alu_inputs_t [1:0]           req_inputs;
   logic        [1:0]           req_grant;
   logic                        alu_possible_issue;
   logic        [2:0]           alu_id;
   alu_inputs_t                 alu_inputs;
   logic                        alu_ready;
   logic                        alu_done;
   logic        [2:0]           alu_wb_id;
   logic        [31:0]          alu_wb_rd;
   logic        [1:0]           wb_valid;
   logic        [1:0][2:0]      wb_id;
   logic        [1:0][31:0]     wb_rd;
   logic        [1:0]           wb_ack;
   logic        [1:0][SW-1:0]   stall_cnt;

   alu_share_arbiter #(.NUM_CORES(2), .ID_W(3), .XLEN(32), .STALL_CNT_W(SW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_id(req_id), .req_inputs(req_inputs),
      .req_grant(req_grant),
      .alu_possible_issue(alu_possible_issue), .alu_id(alu_id),
      .alu_inputs(alu_inputs), .alu_ready(alu_ready),
      .alu_done(alu_done), .alu_wb_id(alu_wb_id), .alu_wb_rd(alu_wb_rd),
      .wb_valid(wb_valid), .wb_id(wb_id), .wb_rd(wb_rd), .wb_ack(wb_ack),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_fn(input alu_inputs_t x);
      case (x.op)
         ALU_ADD: return x.in1 + x.in2;
         ALU_SUB: return x.in1 - x.in2;
         ALU_AND: return x.in1 & x.in2;
         default: return x.in1 ^ x.in2;
      endcase
   endfunction

   function automatic alu_inputs_t mk(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
      alu_inputs_t r;
      r.op = op; r.in1 = a; r.in2 = b;
      return r;
   endfunction

   function automatic alu_inputs_t rnd_in();
      return mk(alu_op_t'($urandom_range(0, 3)), $urandom, $urandom);
   endfunction

   // Stand-in single-cycle ALU
   assign alu_done  = alu_possible_issue;
   assign alu_wb_id = alu_id;
   assign alu_wb_rd = alu_fn(alu_inputs);

   typedef struct { logic [1:0] grant; logic [1:0] full; logic [SW-1:0] s0; logic [SW-1:0] s1; } cyc_t;
   typedef struct { logic [2:0] id; logic [31:0] rd; } res_t;

   cyc_t q_cyc[$];
   res_t q_res0[$];
   res_t q_res1[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: which core owns a result, whether it is blocked, how long it waited.
   logic            m_last;
   logic [1:0]      m_full;
   logic [SW-1:0]   m_stall [2];

   task automatic model_reset();
      m_last = 1'b1;
      m_full = 2'b00;
      m_stall[0] = '0;
      m_stall[1] = '0;
      q_cyc.delete();
      q_res0.delete();
      q_res1.delete();
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] a, input logic rdy,
                        input alu_inputs_t i0, input alu_inputs_t i1,
                        input logic [2:0] d0, input logic [2:0] d1);
      cyc_t       e;
      res_t       r;
      logic [1:0] el;
      logic [1:0] g;
      @(posedge clk); #1;
      req_valid = v; wb_ack = a; alu_ready = rdy;
      req_inputs[0] = i0; req_inputs[1] = i1;
      req_id[0] = d0; req_id[1] = d1;
      for (int c = 0; c < 2; c++) el[c] = v[c] && rdy && (!m_full[c] || a[c]);
      if (el == 2'b11) g = m_last ? 2'b10 : 2'b01;
      else             g = el;
      if (el == 2'b11) g = (m_last == 1'b1) ? 2'b01 : 2'b10;
      e.grant = g; e.full = m_full; e.s0 = m_stall[0]; e.s1 = m_stall[1];
      q_cyc.push_back(e);
      if (g[0]) begin r.id = d0; r.rd = alu_fn(i0); q_res0.push_back(r); end
      if (g[1]) begin r.id = d1; r.rd = alu_fn(i1); q_res1.push_back(r); end
      for (int c = 0; c < 2; c++) begin
         m_full[c] = g[c] | (m_full[c] & ~a[c]);
         if (v[c] && !g[c] && m_stall[c] != SMAX) m_stall[c] = m_stall[c] + 1'b1;
      end
      if (g != 2'b00) m_last = g[1];
   endtask

   task automatic idle(input logic [1:0] a);
      drive(2'b00, a, 1'b1, mk(ALU_ADD, 0, 0), mk(ALU_ADD, 0, 0), 3'd0, 3'd0);
   endtask

   task automatic async_reset(input bit chk_full);
      @(posedge clk); #1;
      if (chk_full) check("pre_reset_wb_valid", {30'd0, wb_valid}, 32'd3);
      req_valid = 2'b11; wb_ack = 2'b00; alu_ready = 1'b1;
      #1 rst = 1'b0;
      #1;
      check("rst_wb_valid", {30'd0, wb_valid}, 32'd0);
      check("rst_stall_cnt", {24'd0, stall_cnt}, 32'd0);
      check("rst_req_grant", {30'd0, req_grant}, 32'd0);
      check("rst_possible_issue", {31'd0, alu_possible_issue}, 32'd0);
      check("rst_wb_rd0", wb_rd[0], 32'd0);
      req_valid = 2'b00;
      model_reset();
      #4 rst = 1'b1;
   endtask

   // Monitor: compares DUT outputs with the queued expectations.
   logic [1:0] pend = 2'b00;
   always @(negedge clk) begin
      cyc_t e;
      res_t r;
      if (!rst) begin
         pend = 2'b00;
      end else begin
         if (pend[0]) begin
            if (q_res0.size() == 0) check("res0_unexpected", 32'd1, 32'd0);
            else begin
               r = q_res0.pop_front();
               check("wb_id0", {29'd0, wb_id[0]}, {29'd0, r.id});
               check("wb_rd0", wb_rd[0], r.rd);
            end
         end
         if (pend[1]) begin
            if (q_res1.size() == 0) check("res1_unexpected", 32'd1, 32'd0);
            else begin
               r = q_res1.pop_front();
               check("wb_id1", {29'd0, wb_id[1]}, {29'd0, r.id});
               check("wb_rd1", wb_rd[1], r.rd);
            end
         end
         pend = 2'b00;
         if (q_cyc.size() != 0) begin
            e = q_cyc.pop_front();
            check("grant", {30'd0, req_grant}, {30'd0, e.grant});
            check("wb_valid", {30'd0, wb_valid}, {30'd0, e.full});
            check("stall0", {28'd0, stall_cnt[0]}, {28'd0, e.s0});
            check("stall1", {28'd0, stall_cnt[1]}, {28'd0, e.s1});
            pend = req_grant;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid = 2'b11; wb_ack = 2'b00; alu_ready = 1'b1;
      req_id = '0; req_inputs = '0;
      model_reset();
      #12;
      check("init_grant", {30'd0, req_grant}, 32'd0);
      check("init_issue", {31'd0, alu_possible_issue}, 32'd0);
      check("init_wb_valid", {30'd0, wb_valid}, 32'd0);
      check("init_stall", {24'd0, stall_cnt}, 32'd0);
      check("init_wb_id", {26'd0, wb_id}, 32'd0);
      req_valid = 2'b00;
      #5 rst = 1'b1;

      // Single requester, then ack colliding with a new capture
      drive(2'b01, 2'b00, 1'b1, mk(ALU_ADD, 5, 7), mk(ALU_ADD, 0, 0), 3'd3, 3'd0);
      @(negedge clk); check("single_grant", {30'd0, req_grant}, 32'd1);
      idle(2'b00);
      @(negedge clk);
      check("single_valid", {31'd0, wb_valid[0]}, 32'd1);
      check("single_rd", wb_rd[0], 32'd12);
      check("single_id", {29'd0, wb_id[0]}, 32'd3);
      drive(2'b01, 2'b01, 1'b1, mk(ALU_SUB, 10, 3), mk(ALU_ADD, 0, 0), 3'd5, 3'd0);
      @(negedge clk); check("collide_grant", {30'd0, req_grant}, 32'd1);
      idle(2'b00);
      @(negedge clk);
      check("collide_valid", {31'd0, wb_valid[0]}, 32'd1);
      check("collide_rd", wb_rd[0], 32'd7);

      // Tie and round-robin from reset
      async_reset(1'b0);
      for (int i = 0; i < 4; i++) begin
         drive(2'b11, 2'b11, 1'b1, rnd_in(), rnd_in(), 3'(i), 3'(i + 4));
         @(negedge clk); check("tie_grant", {30'd0, req_grant}, (i % 2 == 0) ? 32'd1 : 32'd2);
      end
      idle(2'b11);
      @(negedge clk);
      check("tie_stall0", {28'd0, stall_cnt[0]}, 32'd2);
      check("tie_stall1", {28'd0, stall_cnt[1]}, 32'd2);

      // Core 1 blocked by its own full buffer
      async_reset(1'b0);
      drive(2'b10, 2'b00, 1'b1, mk(ALU_ADD, 0, 0), mk(ALU_ADD, 1, 1), 3'd0, 3'd1);
      for (int i = 0; i < 5; i++) begin
         drive(2'b10, 2'b00, 1'b1, mk(ALU_ADD, 0, 0), rnd_in(), 3'd0, 3'd2);
         @(negedge clk); check("full_no_grant", {31'd0, req_grant[1]}, 32'd0);
      end
      drive(2'b10, 2'b10, 1'b1, mk(ALU_ADD, 0, 0), mk(ALU_XOR, 32'hF0, 32'h0F), 3'd0, 3'd6);
      @(negedge clk);
      check("full_stall1", {28'd0, stall_cnt[1]}, 32'd5);
      check("full_ack_grant", {30'd0, req_grant}, 32'd2);
      idle(2'b00);
      @(negedge clk);
      check("full_new_rd", wb_rd[1], 32'd255);
      check("full_new_id", {29'd0, wb_id[1]}, 32'd6);

      // Saturation under backpressure
      async_reset(1'b0);
      for (int i = 0; i < 20; i++)
         drive(2'b01, 2'b00, 1'b0, rnd_in(), rnd_in(), 3'd1, 3'd1);
      idle(2'b00);
      @(negedge clk); check("sat_stall0", {28'd0, stall_cnt[0]}, 32'd15);

      // Randomized traffic
      async_reset(1'b0);
      for (int i = 0; i < 400; i++)
         drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0),
               rnd_in(), rnd_in(), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

      // Async reset with both buffers valid
      idle(2'b11);
      drive(2'b11, 2'b00, 1'b1, rnd_in(), rnd_in(), 3'd1, 3'd2);
      drive(2'b11, 2'b00, 1'b1, rnd_in(), rnd_in(), 3'd3, 3'd4);
      async_reset(1'b1);
      drive(2'b11, 2'b00, 1'b1, rnd_in(), rnd_in(), 3'd5, 3'd6);
      @(negedge clk); check("post_reset_tie", {30'd0, req_grant}, 32'd1);
      idle(2'b11);
      idle(2'b11);
      @(negedge clk); #1;
      check("drain", q_res0.size() + q_res1.size() + q_cyc.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Time-multiplexes one single-cycle ALU unit between the two cores of the dual-core build. Each core presents ALU issue requests; the arbiter grants at most one per cycle in round-robin order. It drives the shared ALU's issue side and captures the same-cycle writeback into a one-entry result buffer per core. It sits between each core's decode/issue stage and the shared `alu_unit`, replacing the per-core ALU.

## Interface
- `NUM_CORES`, 2: number of requesters; fixed at 2 for this revision.
- `ID_W`, 3: instruction-id width, matching `issue.id` and `wb.id`.
- `XLEN`, 32: result width.
- `STALL_CNT_W`, 16: width of the per-core saturating stall counters.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; held state is cleared immediately on assertion.
- `req_valid[c]`  in  1 per core  core c has an ALU op ready to issue.
- `req_id[c]`  in  ID_W per core  id of core c's op.
- `req_inputs[c]`  in  alu_inputs_t per core  operands and control for core c's op.
- `req_grant[c]`  out  1 per core  core c's op is accepted this cycle; request and grant form a same-cycle handshake.
- `alu_possible_issue`  out  1  drives the shared ALU's `issue.possible_issue`.
- `alu_id`  out  ID_W  drives `issue.id`.
- `alu_inputs`  out  alu_inputs_t  muxed operands to the ALU.
- `alu_ready`  in  1  `issue.ready` from the ALU.
- `alu_done`  in  1  `wb.done` from the ALU.
- `alu_wb_id`  in  ID_W  `wb.id` from the ALU.
- `alu_wb_rd`  in  XLEN  `wb.rd` from the ALU.
- `wb_valid[c]`  out  1 per core  core c's result buffer holds a result.
- `wb_id[c]`  out  ID_W per core  buffered id.
- `wb_rd[c]`  out  XLEN per core  buffered result.
- `wb_ack[c]`  in  1 per core  core c consumes its buffered result this cycle.
- `stall_cnt[c]`  out  STALL_CNT_W per core  count of cycles core c requested but was not granted; saturating.

## Operation
- **Eligibility.** Core c is eligible when all of the following hold:
  - `req_valid[c]` is high.
  - `alu_ready` is high.
  - Its buffer is free: `!wb_valid[c] || wb_ack[c]`.
- **Arbitration.** This is combinational, with one grant per cycle.
  - If exactly one core is eligible, it is granted.
  - If both are eligible, the grant goes to the core that is not `last_grant`.
- **State.**
  - `last_grant` is a 1-bit register. It updates to the granted core on every grant and holds otherwise. Reset value is 1, so core 0 wins the first tie.
  - `owner` is a 1-bit register holding the granted core index, registered alongside the grant.
- **ALU drive.**
  - `alu_possible_issue` is the OR of all `req_grant` bits.
  - `alu_id` and `alu_inputs` are muxed from the granted core.
  - When there is no grant, `alu_id` and `alu_inputs` are driven from core 0 and are don't-care.
- **Capture.** The ALU completes in the same cycle: `alu_done` equals `alu_possible_issue`.
  - On `alu_done`, the rising edge writes `alu_wb_rd` and `alu_wb_id` into the granted core's buffer and sets its `wb_valid`.
  - If `alu_wb_id` differs from the granted `req_id`, that is a protocol error and is covered by an assertion.
- **Buffer.**
  - `wb_valid[c]` clears on `wb_ack[c]` unless a new capture for core c happens in the same cycle.
  - Simultaneous ack and capture for core c: the new result replaces the old one and `wb_valid` stays 1.
- **Stall counter.**
  - `stall_cnt[c]` increments when `req_valid[c]` is high and `req_grant[c]` is low.
  - It saturates at all-ones and never wraps.
- **Ack on empty.** `wb_ack[c]` while `wb_valid[c]` is 0 is ignored.

## Timing
- **Request to result.** A request granted in cycle N appears on `wb_valid`/`wb_rd` in cycle N+1.
- **Throughput.** One op per cycle total. Each core sustains one op per cycle only if it acks its result in the same cycle it is presented.
- **Grant path.** `req_grant` is combinational from `req_valid`, `alu_ready`, `wb_valid`, `wb_ack` and `last_grant`. It has no path from `alu_wb_*`.
- **Reset values.**
  - `wb_valid` = 0, `wb_id` = 0, `wb_rd` = 0.
  - `stall_cnt` = 0.
  - `last_grant` = 1.
  - `req_grant` and `alu_possible_issue` are 0 while `rst` is low.
- **Reset mid-operation.** An op granted in the cycle `rst` asserts is dropped and never captured. After deassertion, arbitration restarts with core 0 having tie priority.
- **Backpressure.** If `alu_ready` is 0, no grant is made and the stall counters of all requesting cores increment.

## Test plan
- **Single requester.** Core 0 issues id 3, `in1`=5, `in2`=7, ADD with `alu_ready`=1.
  - Required: `req_grant[0]`=1 in cycle N.
  - Required: `wb_valid[0]`=1, `wb_rd[0]`=12, `wb_id[0]`=3 in cycle N+1.
- **Tie and round-robin.** Both cores request continuously from reset, both acking every cycle.
  - Required: grants alternate 0,1,0,1 over 4 cycles.
  - Required: `stall_cnt` = {2,2}.
- **Buffer full.** Core 1's buffer holds a result and `wb_ack[1]`=0 while core 1 requests.
  - Required: `req_grant[1]`=0 for 5 cycles and `stall_cnt[1]`=5.
  - Required: when `wb_ack[1]` is raised, grant occurs in that same cycle and the new result lands at the next edge.
- **Ack and capture collide.** Core 0 acks result A while being granted op B (SUB 10-3).
  - Required: next cycle `wb_valid[0]`=1 and `wb_rd[0]`=7.
- **Saturation.** Set `STALL_CNT_W`=4 and hold a core requesting with `alu_ready`=0 for 20 cycles.
  - Required: the counter stops at 15.
- **Async reset.** Assert `rst` low mid-cycle while both buffers are valid.
  - Required: `wb_valid`=0 and `stall_cnt`=0 immediately, before the next edge.
  - Required: after release, the first tie is granted to core 0.
